// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-requester round-robin arbiter with grant hold timeout
// Grant is held until done, requester drop, en=0, or MAX_HOLD cycles elapse.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nx;
  logic [2:0]         ptr, ptr_nx;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nx;
  logic [7:0]         gnt_nx;
  logic [2:0]         gnt_idx_nx;
  logic               gnt_valid_nx;
  logic               timeout_nx;

  logic [2:0]         winner;
  logic [2:0]         cand;
  logic               found;
  logic               rel_en, rel_done, rel_drop, rel_max;

  // Walk from the farthest offset down so the closest set bit to ptr wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rel_en   = !en;
    rel_done = done;
    rel_drop = !req[gnt_idx];
    rel_max  = (hold_cnt == CNT_W'(MAX_HOLD));
  end

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    hold_cnt_nx  = hold_cnt;
    gnt_nx       = gnt;
    gnt_idx_nx   = gnt_idx;
    gnt_valid_nx = gnt_valid;
    timeout_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (en && found) begin
          state_nx     = GRANT;
          gnt_idx_nx   = winner;
          gnt_nx       = 8'b1 << winner;
          gnt_valid_nx = 1'b1;
          hold_cnt_nx  = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel_en || rel_done || rel_drop || rel_max) begin
          state_nx     = IDLE;
          gnt_nx       = 8'h00;
          gnt_valid_nx = 1'b0;
          ptr_nx       = gnt_idx + 3'd1;
          // Timeout flags only a purely forced release.
          timeout_nx   = rel_max && !(rel_en || rel_done || rel_drop);
        end else begin
          hold_cnt_nx  = hold_cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_cnt_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= gnt_idx_nx;
      gnt_valid <= gnt_valid_nx;
      timeout   <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - self-checking bench for rr_arbiter_8
// Directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic [7:0] req   = 8'h00;
  logic       done  = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: who owns the resource, where the search starts, cycles held.
  bit m_busy;
  int m_owner;
  int m_start;
  int m_held;
  bit m_to;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_start = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_edge();
    bit forced;
    bit voluntary;
    m_to = 0;
    if (!m_busy) begin
      if (en && req != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_start + k) % 8]) begin
            m_owner = (m_start + k) % 8;
            break;
          end
        end
        m_busy = 1;
        m_held = 1;
      end
    end else begin
      voluntary = !en || done || !req[m_owner];
      forced    = (m_held == MAX_HOLD);
      if (voluntary || forced) begin
        m_busy  = 0;
        m_start = (m_owner + 1) % 8;
        m_to    = forced && !voluntary;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_model();
    check("gnt", {24'd0, gnt}, m_busy ? (32'd1 << m_owner) : 32'd0);
    check("gnt_idx", {29'd0, gnt_idx}, 32'(m_owner));
    check("gnt_valid", {31'd0, gnt_valid}, {31'd0, m_busy});
    check("timeout", {31'd0, timeout}, {31'd0, m_to});
    check("onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    int seq [$];
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    check("rst_gnt", {24'd0, gnt}, 32'h00);
    check("rst_idx", {29'd0, gnt_idx}, 32'd0);
    check("rst_valid", {31'd0, gnt_valid}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;

    // Single request to 4, release by done, then pointer sits at 5.
    en = 1; req = 8'h10;
    step();
    check("single_gnt", {24'd0, gnt}, 32'h10);
    check("single_idx", {29'd0, gnt_idx}, 32'd4);
    done = 1;
    step();
    check("single_rel", {24'd0, gnt}, 32'h00);
    done = 0; req = 8'h21;
    step();
    check("ptr5_idx", {29'd0, gnt_idx}, 32'd5);
    done = 1;
    step();

    // Full contention rotation from a fresh reset.
    @(negedge clock);
    reset = 1; #1; model_reset(); #1; reset = 0;
    req = 8'hFF; done = 1;
    for (int g = 0; g < 9; g++) begin
      step();
      check("rot_idx", {29'd0, gnt_idx}, 32'(g % 8));
      check("rot_valid", {31'd0, gnt_valid}, 32'd1);
      step();
      check("rot_dead", {31'd0, gnt_valid}, 32'd0);
    end

    // Pointer wrap with skipping: serve 6, then 0x81 goes to 7, then 0x01 to 0.
    done = 0; req = 8'h40;
    step();
    check("wrap6", {29'd0, gnt_idx}, 32'd6);
    done = 1; step();
    done = 0; req = 8'h81; step();
    check("wrap7", {29'd0, gnt_idx}, 32'd7);
    done = 1; step();
    done = 0; req = 8'h01; step();
    check("wrap0", {29'd0, gnt_idx}, 32'd0);
    done = 1; step();

    // Timeout: grant to 1 held MAX_HOLD cycles, pulse, dead cycle, regrant.
    done = 0; req = 8'h02;
    for (int c = 0; c < MAX_HOLD; c++) begin
      step();
      check("to_hold", {24'd0, gnt}, 32'h02);
      check("to_nopulse", {31'd0, timeout}, 32'd0);
    end
    step();
    check("to_pulse", {31'd0, timeout}, 32'd1);
    check("to_dead", {31'd0, gnt_valid}, 32'd0);
    step();
    check("to_clear", {31'd0, timeout}, 32'd0);
    check("to_regrant", {24'd0, gnt}, 32'h02);
    req = 8'h00; step();

    // Release causes: requester drop, then en low; en low blocks grants.
    req = 8'h08; step();
    check("rc_idx3", {29'd0, gnt_idx}, 32'd3);
    req = 8'h00; step();
    check("rc_drop", {31'd0, gnt_valid}, 32'd0);
    check("rc_drop_to", {31'd0, timeout}, 32'd0);
    req = 8'h08; step();
    en = 0; step();
    check("rc_en", {31'd0, gnt_valid}, 32'd0);
    check("rc_en_to", {31'd0, timeout}, 32'd0);
    req = 8'hFF;
    repeat (3) begin
      step();
      check("en0_nogrant", {24'd0, gnt}, 32'h00);
    end

    // Async reset between edges while granted to 5.
    en = 1; req = 8'h20; step();
    check("ar_pre", {24'd0, gnt}, 32'h20);
    #2; reset = 1; #1;
    model_reset();
    check("ar_gnt", {24'd0, gnt}, 32'h00);
    check("ar_valid", {31'd0, gnt_valid}, 32'd0);
    #2; reset = 0;
    req = 8'hFF; step();
    check("ar_first", {29'd0, gnt_idx}, 32'd0);
    done = 1; step();

    // Randomized traffic; requests are sometimes held to reach the hold limit.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) != 0)
        req = 8'($urandom) & 8'($urandom);
      en   = ($urandom_range(0, 15) != 0);
      done = ($urandom_range(0, 5) == 0);
      step();
      if (timeout) seq.push_back(n);
    end
    check("rand_saw_timeout", {31'd0, seq.size() > 0}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
